// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and per-state control decode for the multi-cycle MIPS controller.
// Latency: none (package only).
// Backpressure: none (package only).
package mips_ctrl_pkg;

    // ALU operation codes; the ALU decodes these same values.
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_NOR    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_BRANCH = 4'b1000;
    localparam logic [3:0] ALU_JR     = 4'b1001;
    localparam logic [3:0] ALU_LUI    = 4'b1010;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // Datapath mux selects
    localparam logic       SRCA_PC        = 1'b0;
    localparam logic       SRCA_REG       = 1'b1;
    localparam logic [1:0] SRCB_REG       = 2'd0;
    localparam logic [1:0] SRCB_FOUR      = 2'd1;
    localparam logic [1:0] SRCB_IMM       = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2   = 2'd3;
    localparam logic [1:0] PCSRC_ALU      = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT   = 2'd1;
    localparam logic [1:0] PCSRC_JUMP     = 2'd2;
    localparam logic [1:0] PCSRC_JR       = 2'd3;
    localparam logic [1:0] REGDST_RT      = 2'd0;
    localparam logic [1:0] REGDST_RD      = 2'd1;
    localparam logic [1:0] REGDST_RA      = 2'd2;
    localparam logic [1:0] MEMTOREG_ALU   = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR   = 2'd1;
    localparam logic [1:0] MEMTOREG_PC    = 2'd2;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
        MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, HALT
    } state_t;

    // Registered control word. The *_en / done_on_ready / br_* fields are not
    // outputs themselves; the top combines them with same-cycle status inputs.
    typedef struct packed {
        logic [3:0] alu_operation;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       fetch_en;      // ir_write/pc_write gated by mem_ready
        logic       pc_write_u;    // unconditional PC load
        logic       br_en;         // PC load gated by alu_zero
        logic       br_ne;         // invert the branch condition (bne)
        logic       jr_en;         // PC load gated by alu_is_jr
        logic [1:0] pc_source;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       done_u;        // unconditional retirement pulse
        logic       done_on_ready; // retirement gated by mem_ready (sw)
        logic       illegal;
    } ctrl_t;

    function automatic logic opcode_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                          OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    endfunction

    // R-type functs that compute a result and go on to register writeback.
    function automatic logic funct_is_alu(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL};
    endfunction

    // Control word for the cycle spent in state s.
    function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] op,
                                          input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read      = 1'b1;
                c.iord          = 1'b0;
                c.alu_src_a     = SRCA_PC;
                c.alu_src_b     = SRCB_FOUR;
                c.alu_operation = ALU_ADD;
                c.fetch_en      = 1'b1;
                c.pc_source     = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_a     = SRCA_PC;
                c.alu_src_b     = SRCB_IMM_SH2;
                c.alu_operation = ALU_ADD;
            end
            EXEC_R: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_REG;
                case (fn)
                    FN_ADD:  c.alu_operation = ALU_ADD;
                    FN_SUB:  c.alu_operation = ALU_SUB;
                    FN_AND:  c.alu_operation = ALU_AND;
                    FN_OR:   c.alu_operation = ALU_OR;
                    FN_NOR:  c.alu_operation = ALU_NOR;
                    FN_SLL:  c.alu_operation = ALU_SLL;
                    FN_SRL:  c.alu_operation = ALU_SRL;
                    FN_JR: begin
                        c.alu_operation = ALU_JR;
                        c.pc_source     = PCSRC_JR;
                        c.jr_en         = 1'b1;
                        c.done_u        = 1'b1;
                    end
                    default: c.illegal = 1'b1;
                endcase
            end
            WB_R: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RD;
                c.mem_to_reg = MEMTOREG_ALU;
                c.done_u     = 1'b1;
            end
            EXEC_I: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                case (op)
                    OP_ORI:  c.alu_operation = ALU_OR;
                    OP_LUI:  c.alu_operation = ALU_LUI;
                    default: c.alu_operation = ALU_ADD;
                endcase
            end
            WB_I: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = MEMTOREG_ALU;
                c.done_u     = 1'b1;
            end
            MEM_ADDR: begin
                c.alu_src_a     = SRCA_REG;
                c.alu_src_b     = SRCB_IMM;
                c.alu_operation = ALU_ADD;
            end
            MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEM_WR: begin
                c.mem_write     = 1'b1;
                c.iord          = 1'b1;
                c.done_on_ready = 1'b1;
            end
            WB_MEM: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = REGDST_RT;
                c.mem_to_reg = MEMTOREG_MDR;
                c.done_u     = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = SRCA_REG;
                c.alu_src_b     = SRCB_REG;
                c.alu_operation = ALU_SUB;
                c.pc_source     = PCSRC_ALUOUT;
                c.br_en         = 1'b1;
                c.br_ne         = (op == OP_BNE);
                c.done_u        = 1'b1;
            end
            JUMP: begin
                c.pc_source  = PCSRC_JUMP;
                c.pc_write_u = 1'b1;
                c.done_u     = 1'b1;
                if (op == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = REGDST_RA;
                    c.mem_to_reg = MEMTOREG_PC;
                end
            end
            default: c = '0;   // IDLE, HALT
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mem_timeout.sv
// Memory-wait watchdog: counts stalled cycles in a memory state, flags a timeout, holds a sticky error.
// Latency: timeout is combinational in the stalled cycle that would reach MEM_TIMEOUT; mem_error registers on that edge.
// Backpressure: none; mem_ready in the final cycle wins over the timeout.
// Ports: clk, reset (async active-low), active (FSM in FETCH/MEM_RD/MEM_WR), mem_ready,
//        timeout (stall limit hit this cycle), mem_error (sticky until reset).
module mips_mem_timeout #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout,
    output logic mem_error
);

    logic [TO_W-1:0] count;

    // count holds stalled cycles already spent; this cycle is the last allowed one.
    assign timeout = active & ~mem_ready & (count == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            mem_error <= 1'b0;
        end else begin
            // Every memory state is left only through mem_ready (or timeout),
            // so clearing on completion also clears on entry to the next one.
            if (!active || mem_ready) begin
                count <= '0;
            end else begin
                count <= count + TO_W'(1);
            end
            if (timeout) begin
                mem_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback over one shared memory port.
// Latency: zero-wait memory gives R/I-type 4, lw 5, sw 4, beq/bne/j/jal/jr 3 cycles.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready; MEM_TIMEOUT stalled cycles -> HALT with mem_error.
// Ports: clk, reset (async active-low); opcode/funct from IR; alu_zero/alu_is_jr from ALU;
//        mem_ready from memory; ALU/mux selects, memory requests, write enables,
//        instr_done/illegal_instr pulses and sticky mem_error out.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_is_jr,
    input  logic       mem_ready,
    output logic [3:0] alu_operation,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       mem_error
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   mem_active;
    logic   timeout;

    assign mem_active = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

    mips_mem_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_mem_timeout (
        .clk      (clk),
        .reset    (reset),
        .active   (mem_active),
        .mem_ready(mem_ready),
        .timeout  (timeout),
        .mem_error(mem_error)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                if (mem_ready)    state_nxt = DECODE;
                else if (timeout) state_nxt = HALT;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:               state_nxt = EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: state_nxt = EXEC_I;
                    OP_LW, OP_SW:           state_nxt = MEM_ADDR;
                    OP_BEQ, OP_BNE:         state_nxt = BRANCH;
                    OP_J, OP_JAL:           state_nxt = JUMP;
                    default:                state_nxt = FETCH;
                endcase
            end
            EXEC_R:   state_nxt = funct_is_alu(funct) ? WB_R : FETCH;
            EXEC_I:   state_nxt = WB_I;
            MEM_ADDR: state_nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready)    state_nxt = WB_MEM;
                else if (timeout) state_nxt = HALT;
            end
            MEM_WR: begin
                if (mem_ready)    state_nxt = FETCH;
                else if (timeout) state_nxt = HALT;
            end
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: state_nxt = FETCH;
            HALT:     state_nxt = HALT;
            default:  state_nxt = IDLE;
        endcase
    end

    // The control word is registered from the next state, so it always matches
    // the decode of the current state. IR is latched at the end of FETCH, so
    // opcode/funct are already valid when the post-DECODE word is computed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_decode(state_nxt, opcode, funct);
        end
    end

    assign alu_operation = ctrl_q.alu_operation;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign iord          = ctrl_q.iord;
    assign pc_source     = ctrl_q.pc_source;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;

    // Same-cycle qualifications; every enable term is a reset-cleared register.
    assign ir_write   = ctrl_q.fetch_en & mem_ready;
    assign pc_write   = ctrl_q.pc_write_u
                      | (ctrl_q.fetch_en & mem_ready)
                      | (ctrl_q.br_en & (alu_zero ^ ctrl_q.br_ne))
                      | (ctrl_q.jr_en & alu_is_jr);
    assign instr_done = ctrl_q.done_u | (ctrl_q.done_on_ready & mem_ready);

    // An unknown opcode is only visible once IR has been latched, i.e. during
    // DECODE itself, so that case is flagged combinationally.
    assign illegal_instr = ctrl_q.illegal | ((state == DECODE) && !opcode_legal(opcode));

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_is_jr;
    logic       mem_ready;
    logic [3:0] alu_operation;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_error;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .alu_zero     (alu_zero),
        .alu_is_jr    (alu_is_jr),
        .mem_ready    (mem_ready),
        .alu_operation(alu_operation),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .iord         (iord),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_source    (pc_source),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .instr_done   (instr_done),
        .illegal_instr(illegal_instr),
        .mem_error    (mem_error)
    );

    logic [21:0] outv;
    assign outv = {alu_operation, alu_src_a, alu_src_b, mem_read, mem_write, iord,
                   ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg,
                   instr_done, illegal_instr, mem_error};

    function automatic logic [21:0] pk(
        input logic [3:0] op, input logic sa, input logic [1:0] sb,
        input logic mr, input logic mw, input logic io,
        input logic irw, input logic pcw, input logic [1:0] pcs,
        input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
        input logic dn, input logic il, input logic er);
        return {op, sa, sb, mr, mw, io, irw, pcw, pcs, rw, rd, m2r, dn, il, er};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then drive the status inputs for the new cycle.
    task automatic cyc(input logic rdy, input logic z, input logic jr);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        alu_zero  = z;
        alu_is_jr = jr;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [21:0] v_fetch_wait, v_fetch_rdy, v_decode, v_decode_ill, v_exec_add, v_wb_r;
        logic [21:0] v_beq_t, v_bne_nt, v_bne_t, v_mem_addr, v_mem_rd, v_wb_mem;
        logic [21:0] v_mem_wr_wait, v_mem_wr_done, v_halt, v_jal, v_jr, v_exec_lui, v_wb_i;

        //                 op       sa  sb   mr mw io irw pcw pcs  rw rd   m2r  dn il er
        v_fetch_wait  = pk(4'b0011, 0, 2'd1, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_fetch_rdy   = pk(4'b0011, 0, 2'd1, 1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_decode      = pk(4'b0011, 0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_decode_ill  = pk(4'b0011, 0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 0);
        v_exec_add    = pk(4'b0011, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_wb_r        = pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 1, 0, 0);
        v_beq_t       = pk(4'b0100, 1, 2'd0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 1, 0, 0);
        v_bne_nt      = pk(4'b0100, 1, 2'd0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 2'd0, 1, 0, 0);
        v_bne_t       = pk(4'b0100, 1, 2'd0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 1, 0, 0);
        v_mem_addr    = pk(4'b0011, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_mem_rd      = pk(4'b0000, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_wb_mem      = pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 1, 0, 0);
        v_mem_wr_wait = pk(4'b0000, 0, 2'd0, 0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_mem_wr_done = pk(4'b0000, 0, 2'd0, 0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 0);
        v_halt        = pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 1);
        v_jal         = pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd2, 1, 0, 0);
        v_jr          = pk(4'b1001, 1, 2'd0, 0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 2'd0, 1, 0, 0);
        v_exec_lui    = pk(4'b1010, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0);
        v_wb_i        = pk(4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 1, 0, 0);

        reset = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; alu_is_jr = 1'b0;
        opcode = 6'h00; funct = 6'h20;

        // Reset, IDLE, FETCH; reset mid-FETCH-wait aborts at once
        #2 chk("reset_outputs", outv, 22'd0);
        @(posedge clk); #1 reset = 1'b1; #1;
        chk("idle_after_reset", outv, 22'd0);
        cyc(0, 0, 0); chk("fetch_after_idle", outv, v_fetch_wait);
        cyc(0, 0, 0); chk("fetch_wait2", outv, v_fetch_wait);
        #2 reset = 1'b0; #1;
        chk("reset_mid_fetch", outv, 22'd0);
        @(posedge clk); #1 reset = 1'b1; #1;
        chk("idle_again", outv, 22'd0);

        // add, mem_ready on the third FETCH cycle
        opcode = 6'h00; funct = 6'h20;
        cyc(0, 0, 0); chk("add_fetch1", outv, v_fetch_wait);
        cyc(0, 0, 0); chk("add_fetch2", outv, v_fetch_wait);
        cyc(1, 0, 0); chk("add_fetch3_rdy", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("add_decode", outv, v_decode);
        cyc(0, 0, 0); chk("add_exec_r", outv, v_exec_add);
        cyc(0, 0, 0); chk("add_wb_r", outv, v_wb_r);

        // beq taken, bne not taken / taken
        opcode = 6'h04;
        cyc(1, 0, 0); chk("beq_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("beq_decode", outv, v_decode);
        cyc(0, 1, 0); chk("beq_branch_zero1", outv, v_beq_t);
        opcode = 6'h05;
        cyc(1, 0, 0); chk("bne_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("bne_decode", outv, v_decode);
        cyc(0, 1, 0); chk("bne_branch_zero1", outv, v_bne_nt);
        alu_zero = 1'b0; #1;
        chk("bne_branch_zero0", outv, v_bne_t);

        // lw, zero-wait memory: retires in cycle 5
        opcode = 6'h23;
        cyc(1, 0, 0); chk("lw_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("lw_decode", outv, v_decode);
        cyc(0, 0, 0); chk("lw_mem_addr", outv, v_mem_addr);
        cyc(1, 0, 0); chk("lw_mem_rd", outv, v_mem_rd);
        cyc(0, 0, 0); chk("lw_wb_mem", outv, v_wb_mem);
        cyc(0, 0, 0); chk("lw_back_to_fetch", outv, v_fetch_wait);

        // jal, jr, lui
        opcode = 6'h03;
        cyc(1, 0, 0); chk("jal_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("jal_decode", outv, v_decode);
        cyc(0, 0, 0); chk("jal_jump", outv, v_jal);
        opcode = 6'h00; funct = 6'h08;
        cyc(1, 0, 0); chk("jr_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("jr_decode", outv, v_decode);
        cyc(0, 0, 1); chk("jr_exec", outv, v_jr);
        opcode = 6'h0F;
        cyc(1, 0, 0); chk("lui_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("lui_decode", outv, v_decode);
        cyc(0, 0, 0); chk("lui_exec_i", outv, v_exec_lui);
        cyc(0, 0, 0); chk("lui_wb_i", outv, v_wb_i);

        // sw with memory stalled in MEM_WR: 16 stalled cycles -> HALT
        opcode = 6'h2B;
        cyc(1, 0, 0); chk("sw_to_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("sw_to_decode", outv, v_decode);
        cyc(0, 0, 0); chk("sw_to_mem_addr", outv, v_mem_addr);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 0);
            chk($sformatf("sw_to_wait%0d", k), outv, v_mem_wr_wait);
        end
        cyc(0, 0, 0); chk("sw_to_halt", outv, v_halt);
        cyc(1, 0, 0); chk("halt_sticky", outv, v_halt);
        cyc(1, 0, 0); chk("halt_sticky2", outv, v_halt);
        reset = 1'b0; #1;
        chk("reset_clears_error", outv, 22'd0);
        @(posedge clk); #1 reset = 1'b1; mem_ready = 1'b0; #1;
        chk("idle_after_halt", outv, 22'd0);

        // sw with mem_ready on the 16th MEM_WR cycle: success, no error
        cyc(1, 0, 0); chk("sw_ok_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("sw_ok_decode", outv, v_decode);
        cyc(0, 0, 0); chk("sw_ok_mem_addr", outv, v_mem_addr);
        for (int k = 1; k <= 15; k++) begin
            cyc(0, 0, 0);
        end
        chk("sw_ok_wait15", outv, v_mem_wr_wait);
        cyc(1, 0, 0); chk("sw_ok_ready16", outv, v_mem_wr_done);
        cyc(0, 0, 0); chk("sw_ok_back_to_fetch", outv, v_fetch_wait);

        // illegal opcode, then illegal funct
        opcode = 6'h3F;
        cyc(1, 0, 0); chk("illop_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("illop_decode", outv, v_decode_ill);
        cyc(0, 0, 0); chk("illop_back_to_fetch", outv, v_fetch_wait);
        opcode = 6'h00; funct = 6'h3F;
        cyc(1, 0, 0); chk("illfn_fetch", outv, v_fetch_rdy);
        cyc(0, 0, 0); chk("illfn_decode", outv, v_decode);
        cyc(0, 0, 0);
        chk("illfn_illegal", {31'd0, illegal_instr}, 32'd1);
        chk("illfn_no_reg_write", {31'd0, reg_write}, 32'd0);
        chk("illfn_no_done", {31'd0, instr_done}, 32'd0);
        cyc(0, 0, 0); chk("illfn_back_to_fetch", outv, v_fetch_wait);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle control FSM for the MIPS core. It drives the ALU operation/operand-select side of the datapath and consumes the ALU's Zero and isJR flags. It sequences fetch, decode, execute, memory and writeback, with a ready handshake to the shared instruction/data memory. It replaces single-cycle combinational control so that one memory port serves both instruction and data accesses.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before mem_error (valid range 2..255).
TO_W, 8, width of the timeout counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU Zero flag, same cycle
alu_is_jr  in  1  ALU isJR flag, same cycle
mem_ready  in  1  memory completes the current read/write this cycle
alu_operation  out  4  ALU opcode (package constants)
alu_src_a  out  1  0=PC, 1=A reg
alu_src_b  out  2  0=B reg, 1=const 4, 2=signext imm, 3=signext imm<<2
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0=PC address, 1=ALUOut address
ir_write  out  1  latch instruction register
pc_write  out  1  PC load enable (already qualified by branch condition)
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=ALU result (JR)
reg_write  out  1  register file write enable
reg_dst  out  2  0=rt, 1=rd, 2=$31
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
instr_done  out  1  one-cycle pulse on instruction retirement
illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct
mem_error  out  1  sticky memory-timeout flag

Behaviour:
- Outputs are a Moore decode of state, except: ir_write and pc_write in FETCH are qualified by mem_ready; pc_write in BRANCH is qualified by alu_zero; pc_write in EXEC_R(JR) is qualified by alu_is_jr. Every unlisted output is 0 in each state.
- Reset (reset=0, async): state=IDLE, timeout counter=0, mem_error=0, and all outputs 0. IDLE always moves to FETCH on the next edge.
- A reset asserted at any point, including mid-memory-wait, aborts immediately. No write enable may be seen high while reset is low.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, ADD.
  - Stays in FETCH until mem_ready=1.
  - In the mem_ready cycle: ir_write=1, pc_write=1, pc_source=0, and the next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08 addi / 0x0D ori / 0x0F lui -> EXEC_I
  - 0x23 lw / 0x2B sw -> MEM_ADDR
  - 0x04 beq / 0x05 bne -> BRANCH
  - 0x02 j / 0x03 jal -> JUMP
  - any other opcode -> FETCH, with illegal_instr=1 for 1 cycle.
- EXEC_R: alu_src_a=1, alu_src_b=0. funct maps to the ALU op:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL -> next state WB_R.
  - 0x08 JR: op=JR, pc_source=3, pc_write=alu_is_jr, instr_done=1 -> FETCH.
  - Any other funct: illegal_instr=1 -> FETCH.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2; op is ADD (addi), OR (ori) or LUI (lui). Next state WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1; on mem_ready -> WB_MEM.
- MEM_WR: mem_write=1, iord=1; on mem_ready, instr_done=1 -> FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1.
  - pc_write = alu_zero for beq, ~alu_zero for bne.
  - instr_done=1 -> FETCH.
- JUMP: pc_source=2, pc_write=1, instr_done=1. For jal also reg_write=1, reg_dst=2, mem_to_reg=2. -> FETCH.
- Timeout counter:
  - Clears on entry to any memory state and counts each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - When it reaches MEM_TIMEOUT: mem_error=1 and state=HALT.
  - HALT drives all outputs 0 except mem_error and is left only by reset.
  - mem_ready in the same cycle the count reaches MEM_TIMEOUT takes priority as a success.
- Latency with zero-wait memory: R/I-type 4 cycles; lw 5; sw 4; beq/bne, j/jal, jr 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - ALU op constants: AND 0000, OR 0010, ADD 0011, SUB 0100, NOR 0101, SLL 0110, SRL 0111, BRANCH 1000, JR 1001, LUI 1010. The ALU decodes these same constants.
  - Opcode/funct constants.
  - The state enum: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, HALT.
  - Mux-select encodings.
- One sub-module: mips_mem_timeout (counter plus sticky error flag).

Test Plan:
1. Reset pulled low during a FETCH wait -> all outputs 0 immediately. After release: IDLE for 1 cycle, then FETCH with mem_read=1.
2. add (opcode 0x00, funct 0x20), mem_ready high on the 3rd FETCH cycle -> ir_write/pc_write pulse that cycle, then DECODE, EXEC_R (alu_operation=0011), WB_R with reg_write=1, reg_dst=1 and instr_done=1.
3. beq with alu_zero=1 -> pc_write=1, pc_source=1 in BRANCH. bne with alu_zero=1 -> pc_write=0. Both give instr_done=1 on cycle 3.
4. lw with zero-wait memory -> states FETCH, DECODE, MEM_ADDR, MEM_RD (iord=1), WB_MEM (mem_to_reg=1). instr_done on cycle 5.
5. mem_ready held 0 in MEM_WR -> mem_error=1 after 16 cycles, state HALT, no further requests; reset clears it. mem_ready=1 on cycle 16 -> normal retirement with no error.
6. opcode 0x3F, and funct 0x3F with opcode 0x00 -> illegal_instr 1-cycle pulse, reg_write never asserted, back in FETCH the next cycle.
